// File: rtl/minmax_window_tracker.sv
// ---------------------------------------------------------------------------
// minmax_window_tracker
//
// Streaming min/max tracker. Samples arrive on a valid/ready port. The block
// keeps a running minimum and maximum and the 0-based window index at which
// each one was seen. After WINDOW accepted samples it holds a result record
// and presents it on a valid/ready result port. While the result waits, new
// samples are stalled.
//
// Parameters
//   WIDTH   sample/result data width (>= 2)
//   WINDOW  samples per window (>= 2)
//   SIGNED  1: two's-complement compare, 0: unsigned compare
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-high reset
//   clear         in   synchronous window restart (drops any pending result)
//   in_valid      in   sample valid
//   in_data       in   sample value
//   in_ready      out  sample accepted when in_valid & in_ready
//   min_out       out  running/final minimum
//   max_out       out  running/final maximum
//   min_idx       out  window index of min_out
//   max_idx       out  window index of max_out
//   cnt           out  samples accepted in the current window
//   new_min       out  1-cycle pulse: minimum strictly improved
//   new_max       out  1-cycle pulse: maximum strictly improved
//   result_valid  out  window complete, outputs frozen
//   result_ready  in   consumer takes the result
// ---------------------------------------------------------------------------
module minmax_window_tracker #(
    parameter int WIDTH  = 32,
    parameter int WINDOW = 16,
    parameter bit SIGNED = 1'b0,
    localparam int IDX_W = $clog2(WINDOW),
    localparam int CNT_W = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out,
    output logic [IDX_W-1:0] min_idx,
    output logic [IDX_W-1:0] max_idx,
    output logic [CNT_W-1:0] cnt,
    output logic             new_min,
    output logic             new_max,
    output logic             result_valid,
    input  logic             result_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // window empty, waiting for its first sample
        TRACK = 2'd1,  // at least one sample seen, window not yet full
        HOLD  = 2'd2   // window full, result waiting for the consumer
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    state_t     state;
    logic       accept;
    logic       lt_min;
    logic       gt_max;
    logic [IDX_W-1:0] cur_idx;

    // Ready depends on the registered state only, so there is no
    // combinational path from in_valid or result_ready to in_ready.
    assign in_ready = (state != HOLD);
    assign accept   = in_valid & in_ready;

    // While tracking, cnt is at most WINDOW-1 and therefore fits the index.
    assign cur_idx  = cnt[IDX_W-1:0];

    // NOTE: every signal written in an always_comb gets a default at the top
    // of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        lt_min = 1'b0;
        gt_max = 1'b0;
        if (SIGNED) begin
            lt_min = $signed(in_data) < $signed(min_out);
            gt_max = $signed(in_data) > $signed(max_out);
        end else begin
            lt_min = in_data < min_out;
            gt_max = in_data > max_out;
        end
    end

    // NOTE: state is updated with non-blocking assignments so that every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            min_out      <= '0;
            max_out      <= '0;
            min_idx      <= '0;
            max_idx      <= '0;
            cnt          <= '0;
            new_min      <= 1'b0;
            new_max      <= 1'b0;
            result_valid <= 1'b0;
        end else if (clear) begin
            // Same values as reset; a sample offered now is dropped and a
            // pending result is discarded.
            state        <= IDLE;
            min_out      <= '0;
            max_out      <= '0;
            min_idx      <= '0;
            max_idx      <= '0;
            cnt          <= '0;
            new_min      <= 1'b0;
            new_max      <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-armed below.
            new_min <= 1'b0;
            new_max <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        // First sample seeds both extremes; it is not an
                        // improvement, so no pulse.
                        min_out <= in_data;
                        max_out <= in_data;
                        min_idx <= '0;
                        max_idx <= '0;
                        cnt     <= CNT_W'(1);
                        state   <= TRACK;
                    end
                end

                TRACK: begin
                    if (accept) begin
                        // Strict compares: ties keep the earliest index.
                        if (lt_min) begin
                            min_out <= in_data;
                            min_idx <= cur_idx;
                            new_min <= 1'b1;
                        end
                        if (gt_max) begin
                            max_out <= in_data;
                            max_idx <= cur_idx;
                            new_max <= 1'b1;
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_IDX) begin
                            state        <= HOLD;
                            result_valid <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    // Extremes and indices stay visible after the handshake
                    // until the next window's first sample overwrites them.
                    if (result_ready) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        result_valid <= 1'b0;
                    end
                end

                default: begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
